// File: rtl/antisat_pkg.sv
// Shared types and constants for the Anti-SAT key loader.
// The optional checksum beat is enabled with ANTISAT_KEY_CHK_EN.
package antisat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        ERROR = 2'd3
    } ks_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FRAME = 2'd1;
    localparam logic [1:0] ERR_CHK   = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    localparam int DEF_KEY_W   = 40;
    localparam int DEF_CHUNK_W = 8;

endpackage

// File: rtl/antisat_key_chk.sv
// XOR accumulator over key chunks; match compares the running XOR
// against a presented checksum beat. Used only with ANTISAT_KEY_CHK_EN.
module antisat_key_chk #(
    parameter int CHUNK_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               acc_en,
    input  logic [CHUNK_W-1:0] din,
    input  logic [CHUNK_W-1:0] cmp_data,
    output logic               match
);

    logic [CHUNK_W-1:0] acc_q;
    logic [CHUNK_W-1:0] acc_d;

    // Next accumulator value: clear has priority over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q ^ din;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign match = (acc_q == cmp_data);

endmodule

// File: rtl/antisat_key_loader.sv
// Chunked key-store loader that commits the Anti-SAT key atomically.
// Define ANTISAT_KEY_CHK_EN to require a trailing XOR checksum beat.
module antisat_key_loader
    import antisat_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int CHUNK_W = DEF_CHUNK_W,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [CHUNK_W-1:0] key_data,
    input  logic               key_last,
    output logic [KEY_W-1:0]   key_out,
    output logic               armed,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int BEATS = KEY_W / CHUNK_W;
`ifdef ANTISAT_KEY_CHK_EN
    localparam int LAST_BEAT = BEATS;
`else
    localparam int LAST_BEAT = BEATS - 1;
`endif
    localparam int CNT_W = $clog2(BEATS + 2);

    ks_state_t          state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [KEY_W-1:0]   key_out_q, key_out_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [15:0]        idle_q, idle_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               key_ready_q, key_ready_d;
    logic               busy_q, busy_d;
    logic               armed_q, armed_d;
    logic               err_q, err_d;
    logic               accept_s;
    logic               final_s;

    assign accept_s = key_valid & key_ready_q;
    assign final_s  = (beat_q == CNT_W'(LAST_BEAT));

`ifdef ANTISAT_KEY_CHK_EN
    logic chk_ok_s;
    logic chk_acc_s;

    assign chk_acc_s = accept_s & ~load_req & (int'(beat_q) < BEATS);

    antisat_key_chk #(.CHUNK_W(CHUNK_W)) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (load_req),
        .acc_en   (chk_acc_s),
        .din      (key_data),
        .cmp_data (key_data),
        .match    (chk_ok_s)
    );
`endif

    // Next-state, shadow assembly, commit and error classification.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        key_out_d  = key_out_q;
        beat_d     = beat_q;
        idle_d     = idle_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE, ARMED, ERROR: begin
                if (load_req) begin
                    state_d    = LOAD;
                    shadow_d   = '0;
                    key_out_d  = '0;
                    beat_d     = '0;
                    idle_d     = 16'd0;
                    err_code_d = ERR_NONE;
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                if (load_req) begin
                    // Restart: any beat offered in this cycle is dropped.
                    shadow_d = '0;
                    beat_d   = '0;
                    idle_d   = 16'd0;
                end else if (accept_s) begin
                    idle_d = 16'd0;
                    beat_d = beat_q + CNT_W'(1);
                    if (int'(beat_q) < BEATS) begin
                        shadow_d[int'(beat_q)*CHUNK_W +: CHUNK_W] = key_data;
                    end else begin
                        shadow_d = shadow_q;
                    end
                    if (key_last != final_s) begin
                        state_d    = ERROR;
                        key_out_d  = '0;
                        err_code_d = ERR_FRAME;
`ifdef ANTISAT_KEY_CHK_EN
                    end else if (final_s && !chk_ok_s) begin
                        state_d    = ERROR;
                        key_out_d  = '0;
                        err_code_d = ERR_CHK;
`endif
                    end else if (final_s) begin
                        state_d   = ARMED;
                        key_out_d = shadow_d;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (idle_q >= 16'(TIMEOUT - 1)) begin
                    state_d    = ERROR;
                    key_out_d  = '0;
                    err_code_d = ERR_TMO;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                key_out_d = '0;
            end
        endcase
        key_ready_d = (state_d == LOAD);
        busy_d      = (state_d == LOAD);
        armed_d     = (state_d == ARMED);
        err_d       = (state_d == ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            key_out_q   <= '0;
            beat_q      <= '0;
            idle_q      <= 16'd0;
            err_code_q  <= ERR_NONE;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            key_out_q   <= key_out_d;
            beat_q      <= beat_d;
            idle_q      <= idle_d;
            err_code_q  <= err_code_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            armed_q     <= armed_d;
            err_q       <= err_d;
        end
    end

    assign key_ready = key_ready_q;
    assign key_out   = key_out_q;
    assign armed     = armed_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
